obj_dma_copy: RTL and testbench

Copy engine that transfers a block of words from a synchronous-read dual-port RAM (read port, 1-cycle registered read latency) into a destination buffer (sprite/object line list, palette shadow, etc.). It sits directly downstream of the object RAM read port and upstream of the renderer's working buffer. A copy is triggered once per frame (typically at vblank) and produces a one-cycle completion pulse.

---
 rtl/obj_dma_copy_if.sv | 39 +++
 rtl/obj_dma_copy.sv | 136 +++++++++++++
 tb/tb_obj_dma_copy.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/obj_dma_copy_if.sv
// Handshake and bus signals of the object-RAM copy engine.
// OBJ_DMA_ZERO_FILL_EN adds the fill request input.
interface obj_dma_copy_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 9
);
    logic              start;
    logic [ADDR_W-1:0] len;
`ifdef OBJ_DMA_ZERO_FILL_EN
    logic              fill;
`endif
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] src_addr;
    logic [WIDTH-1:0]  src_q;
    logic [ADDR_W-1:0] dst_addr;
    logic [WIDTH-1:0]  dst_data;
    logic              dst_we;

`ifdef OBJ_DMA_ZERO_FILL_EN
    modport master (
        input  start, len, fill, src_q,
        output busy, done, src_addr, dst_addr, dst_data, dst_we
    );
    modport slave (
        output start, len, fill, src_q,
        input  busy, done, src_addr, dst_addr, dst_data, dst_we
    );
`else
    modport master (
        input  start, len, src_q,
        output busy, done, src_addr, dst_addr, dst_data, dst_we
    );
    modport slave (
        output start, len, src_q,
        input  busy, done, src_addr, dst_addr, dst_data, dst_we
    );
`endif
endinterface

// File: rtl/obj_dma_copy.sv
// Block copy from a 1-cycle-latency RAM read port into a destination buffer.
// OBJ_DMA_ZERO_FILL_EN adds a latched fill request that writes zeros instead of RAM data.
module obj_dma_copy #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 9
) (
    input  logic clock,
    input  logic reset_n,
    input  logic ce,
    obj_dma_copy_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              v1_q, v1_d;
    logic              v2_q, v2_d;
    logic [ADDR_W-1:0] a2_q, a2_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
    logic [WIDTH-1:0]  dst_data_q, dst_data_d;
    logic [WIDTH-1:0]  wr_word;
`ifdef OBJ_DMA_ZERO_FILL_EN
    logic              fill_q, fill_d;

    assign wr_word = fill_q ? '0 : bus.src_q;
`else
    assign wr_word = bus.src_q;
`endif

    // Next state: v1 marks the address currently presented, v2 the RAM word now on src_q.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        src_addr_d = src_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        v1_d       = 1'b0;
        v2_d       = v1_q;
        a2_d       = src_addr_q;
        we_d       = v2_q;
        dst_addr_d = dst_addr_q;
        dst_data_d = dst_data_q;
`ifdef OBJ_DMA_ZERO_FILL_EN
        fill_d     = fill_q;
`endif
        if (v2_q) begin
            dst_addr_d = a2_q;
            dst_data_d = wr_word;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = FETCH;
                    len_d      = bus.len;
                    src_addr_d = '0;
                    busy_d     = 1'b1;
                    v1_d       = 1'b1;
`ifdef OBJ_DMA_ZERO_FILL_EN
                    fill_d     = bus.fill;
`endif
                end
            end
            FETCH: begin
                // The increment past len may wrap to 0; that address is never marked valid.
                src_addr_d = ADDR_W'(src_addr_q + 1'b1);
                if (src_addr_q == len_q) begin
                    state_d = DRAIN;
                end else begin
                    v1_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!v1_q && !v2_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state, outputs included, holds while ce is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            src_addr_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            a2_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
`ifdef OBJ_DMA_ZERO_FILL_EN
            fill_q     <= 1'b0;
`endif
        end else if (ce) begin
            state_q    <= state_d;
            len_q      <= len_d;
            src_addr_q <= src_addr_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            a2_q       <= a2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_q       <= we_d;
            dst_addr_q <= dst_addr_d;
            dst_data_q <= dst_data_d;
`ifdef OBJ_DMA_ZERO_FILL_EN
            fill_q     <= fill_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.src_addr = src_addr_q;
    assign bus.dst_we   = we_q;
    assign bus.dst_addr = dst_addr_q;
    assign bus.dst_data = dst_data_q;
endmodule

// File: tb/tb_obj_dma_copy.sv
// Randomized bench for obj_dma_copy: per-ce-edge expectations derived from the edge-numbered timing rules.
module tb_obj_dma_copy;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef OBJ_DMA_ZERO_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic clock;
    logic reset_n;
    logic ce;
    logic fill_r;
    logic [WIDTH-1:0] mem [DEPTH];
    int n_cmp;
    int n_err;

    obj_dma_copy_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    obj_dma_copy #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

`ifdef OBJ_DMA_ZERO_FILL_EN
    assign bus.fill = fill_r;
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Source RAM: registered read, advancing on the same clock enable.
    always @(posedge clock) begin
        if (ce) bus.src_q <= mem[bus.src_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected outputs n accepted ce edges after the start edge E0.
    task automatic check_edge(input int n, input int l, input bit fl);
        bit exp_we;
        check_val("busy", 32'(bus.busy), 32'(n <= l + 2));
        check_val("done", 32'(bus.done), 32'(n == l + 3));
        if (n <= l) check_val("src_addr", 32'(bus.src_addr), 32'(n));
        exp_we = (n >= 2) && (n <= l + 2);
        check_val("dst_we", 32'(bus.dst_we), 32'(exp_we));
        if (exp_we) begin
            check_val("dst_addr", 32'(bus.dst_addr), 32'(n - 2));
            check_val("dst_data", 32'(bus.dst_data), (fl && FILL_EN) ? 32'h0 : 32'(mem[n - 2]));
        end
    endtask

    // ce_mode: 0 always on, 1 alternating, 2 random. abort_n: edge at which reset is pulsed (-1 none).
    task automatic do_copy(input int l, input int ce_mode, input bit hold, input bit fl, input int abort_n);
        int n;
        int writes;
        int cyc;
        n = -1;
        writes = 0;
        cyc = 0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.len   = ADDR_W'(l);
        fill_r    = fl;
        ce        = (ce_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (n < l + 3) begin
            @(posedge clock);
            #1;
            cyc++;
            if (ce) begin
                n++;
                if (bus.dst_we) writes++;
            end
            if (n == 0 && !hold) bus.start = 1'b0;
            if (n >= 0) check_edge(n, l, fl);
            if (ce && n == abort_n) begin
                #2 reset_n = 1'b0;
                #1;
                check_val("abort_busy", 32'(bus.busy), 32'h0);
                check_val("abort_dst_we", 32'(bus.dst_we), 32'h0);
                check_val("abort_done", 32'(bus.done), 32'h0);
                check_val("abort_src_addr", 32'(bus.src_addr), 32'h0);
                @(negedge clock);
                reset_n = 1'b1;
                return;
            end
            if (cyc > 4 * (l + 3) + 40) begin
                check_val("timeout_cycles", 32'(cyc), 32'(4 * (l + 3) + 40));
                bus.start = 1'b0;
                return;
            end
            if (n < l + 3) begin
                @(negedge clock);
                case (ce_mode)
                    0:       ce = 1'b1;
                    1:       ce = ~ce;
                    default: ce = 1'($urandom_range(0, 1));
                endcase
            end
        end
        check_val("write_count", 32'(writes), 32'(l + 1));
    endtask

    initial begin
        reset_n   = 1'b0;
        ce        = 1'b0;
        fill_r    = 1'b0;
        bus.start = 1'b0;
        bus.len   = '0;
        n_cmp     = 0;
        n_err     = 0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = WIDTH'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = WIDTH'(16'hA000 + i);

        #12;
        check_val("rst_busy", 32'(bus.busy), 32'h0);
        check_val("rst_done", 32'(bus.done), 32'h0);
        check_val("rst_dst_we", 32'(bus.dst_we), 32'h0);
        check_val("rst_src_addr", 32'(bus.src_addr), 32'h0);
        check_val("rst_dst_addr", 32'(bus.dst_addr), 32'h0);
        check_val("rst_dst_data", 32'(bus.dst_data), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        ce = 1'b1;

        do_copy(3, 0, 1'b0, 1'b0, -1);
        do_copy(511, 0, 1'b0, 1'b0, -1);
        // start held through the done edge, then immediately re-accepted on the next edge
        do_copy(4, 0, 1'b1, 1'b0, -1);
        do_copy(6, 0, 1'b0, 1'b0, -1);
        do_copy(7, 1, 1'b0, 1'b0, -1);
        do_copy(20, 0, 1'b0, 1'b0, 5);
        do_copy(2, 0, 1'b0, 1'b0, -1);
        for (int t = 0; t < 5; t++) begin
            do_copy(int'($urandom_range(0, 40)), 2, 1'b0, 1'($urandom_range(0, 1)), -1);
        end
        do_copy(3, 0, 1'b0, 1'b1, -1);

        @(negedge clock);
        ce = 1'b1;
        bus.start = 1'b0;
        @(posedge clock);
        #1;
        check_val("end_done", 32'(bus.done), 32'h0);
        check_val("end_busy", 32'(bus.busy), 32'h0);
        check_val("end_dst_we", 32'(bus.dst_we), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
